intr_sequencer: RTL and testbench
=================================

INTR_SEQUENCER -- requirements
Module: intr_sequencer

Interface
REQ-001 SHALL have parameter VECTOR_BASE, default 32'h0000_0100, base address of the interrupt vector table.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles o_flush is held on interrupt entry (legal 1..7).
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_irq  input  4  level-sensitive interrupt requests.
REQ-006 SHALL have port i_intr_en  input  1  global interrupt enable.
REQ-007 SHALL have port i_hazard_full  input  1  pipeline holds combined data and control hazard.
REQ-008 SHALL have port i_ex_valid  input  1  EX stage holds a valid instruction.
REQ-009 SHALL have port i_ex_is_ctrl  input  1  EX instruction is branch, JAL or JALR.
REQ-010 SHALL have port i_ex_mret  input  1  EX instruction is MRET.
REQ-011 SHALL have port i_ex_pc  input  32  PC of the EX instruction.
REQ-012 SHALL have port o_intr_en  output  1  interrupt entry in progress, consumed by the hazard logic.
REQ-013 SHALL have port o_flush  output  1  flush IF/ID/EX.
REQ-014 SHALL have port o_pc_redirect  output  1  one-cycle PC override strobe.
REQ-015 SHALL have port o_pc_target  output  32  PC override value.
REQ-016 SHALL have port o_epc  output  32  saved resume PC.
REQ-017 SHALL have port o_irq_ack  output  4  one-hot acknowledge pulse.
REQ-018 SHALL have port o_in_isr  output  1  handler executing.

Function
REQ-019 SHALL implement states IDLE, WAIT_SAFE, FLUSH, REDIRECT, IN_ISR, RETURN.
REQ-020 IDLE: when i_intr_en=1 and i_irq!=0, SHALL latch cause = lowest set index of i_irq and go to WAIT_SAFE next edge.
REQ-021 WAIT_SAFE: SHALL assert o_intr_en; when i_ex_valid=1, i_ex_is_ctrl=0 and i_hazard_full=0, SHALL capture o_epc<=i_ex_pc and go to FLUSH.
REQ-022 WAIT_SAFE: if i_irq[cause]=0 or i_intr_en=0, SHALL return to IDLE without ack, redirect or EPC update; this check has priority over REQ-021.
REQ-023 FLUSH: SHALL assert o_flush and o_intr_en for exactly FLUSH_CYCLES cycles, counted by a 3-bit counter cleared on entry, then go to REDIRECT.
REQ-024 REDIRECT: SHALL assert for one cycle o_pc_redirect=1, o_pc_target=VECTOR_BASE+{cause,2'b00}, o_irq_ack[cause]=1, o_intr_en=1; then go to IN_ISR.
REQ-025 IN_ISR: SHALL assert o_in_isr; SHALL ignore i_irq (no nesting); on i_ex_valid=1 and i_ex_mret=1 SHALL go to RETURN.
REQ-026 RETURN: SHALL assert for one cycle o_flush=1, o_pc_redirect=1, o_pc_target=o_epc; then go to IDLE.
REQ-027 Pending request during IN_ISR SHALL be taken from IDLE the cycle after RETURN (tail-chain, no lost request).
REQ-028 Outputs not asserted by the current state SHALL be 0; o_pc_target SHALL be 0 when o_pc_redirect=0.
REQ-029 All outputs SHALL be decoded from registered state only (no i_* to o_* combinational path).
REQ-030 Address arithmetic SHALL be 32-bit modulo 2^32; o_epc SHALL hold its value outside WAIT_SAFE capture.

Reset
REQ-031 i_reset=1 SHALL asynchronously force state IDLE, cause 0, flush counter 0, o_epc 0, all outputs 0.
REQ-032 Reset mid-sequence (any state) SHALL discard the sequence; no ack or redirect SHALL issue after release until a new request.

Structure
REQ-033 State enum, cause width (2) and opcode constants SHALL live in shared package intr_pkg.
REQ-034 Lowest-index selection SHALL be sub-module irq_prio_enc (4-bit in, 2-bit index plus valid out).

Verification
REQ-035 i_irq=4'b0110, safe EX at pc 0x40 -> o_epc=0x40, o_flush 2 cycles, o_pc_target=0x104, o_irq_ack=4'b0010.
REQ-036 i_irq=4'b0001 with i_ex_is_ctrl=1 for 3 cycles then 0 at pc 0x88 -> capture delayed, o_epc=0x88, target 0x100.
REQ-037 i_irq=4'b1000 dropped while WAIT_SAFE -> return to IDLE, o_irq_ack, o_flush and o_pc_redirect never asserted.
REQ-038 In IN_ISR, i_irq=4'b0100 held, MRET at EX -> RETURN target=o_epc, then new entry with target 0x108.
REQ-039 i_reset pulsed during FLUSH -> all outputs 0 immediately, o_epc=0, no redirect after release.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt entry/return sequencer.
// State encoding, cause width, RISC-V opcode constants and vector helpers.
package intr_pkg;

  localparam int CAUSE_W = 2;
  typedef logic [CAUSE_W-1:0] cause_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SAFE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_IN_ISR,
    ST_RETURN
  } state_t;

  // Opcodes the decode stage uses to raise i_ex_is_ctrl / i_ex_mret.
  localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [6:0]  OPC_JALR     = 7'b1100111;
  localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
  localparam logic [11:0] FUNCT12_MRET = 12'h302;

  function automatic logic [31:0] vec_offset(input cause_t c);
    return {28'd0, c, 2'b00};
  endfunction

  function automatic logic [3:0] cause_onehot(input cause_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for the four interrupt lines.
// Purely combinational; vld is low when no line is set (idx then 0).
module irq_prio_enc
  import intr_pkg::*;
(
  input  logic [3:0] irq,
  output cause_t     idx,
  output logic       vld
);

  always_comb begin
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (irq[i]) idx = cause_t'(i);
    end
    vld = |irq;
  end

endmodule

// File: rtl/intr_sequencer.sv
// Interrupt entry/return sequencer: waits for a safe EX slot, flushes, vectors, returns on MRET.
// All outputs registered (one cycle after state decision); stalls in WAIT_SAFE while EX is unsafe.
module intr_sequencer
  import intr_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_irq,
  input  logic        i_intr_en,
  input  logic        i_hazard_full,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_ctrl,
  input  logic        i_ex_mret,
  input  logic [31:0] i_ex_pc,
  output logic        o_intr_en,
  output logic        o_flush,
  output logic        o_pc_redirect,
  output logic [31:0] o_pc_target,
  output logic [31:0] o_epc,
  output logic [3:0]  o_irq_ack,
  output logic        o_in_isr
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  cause_t     cause;
  logic [2:0] flush_cnt;
  cause_t     prio_idx;
  logic       prio_vld;
  logic       ex_safe;

  irq_prio_enc u_prio (
    .irq (i_irq),
    .idx (prio_idx),
    .vld (prio_vld)
  );

  assign ex_safe = i_ex_valid && !i_ex_is_ctrl && !i_hazard_full;

  // Outputs are set together with the next state, so each output reflects the state it belongs to.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      cause         <= '0;
      flush_cnt     <= '0;
      o_epc         <= '0;
      o_intr_en     <= 1'b0;
      o_flush       <= 1'b0;
      o_pc_redirect <= 1'b0;
      o_pc_target   <= '0;
      o_irq_ack     <= '0;
      o_in_isr      <= 1'b0;
    end else begin
      o_intr_en     <= 1'b0;
      o_flush       <= 1'b0;
      o_pc_redirect <= 1'b0;
      o_pc_target   <= '0;
      o_irq_ack     <= '0;
      o_in_isr      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_intr_en && prio_vld) begin
            cause     <= prio_idx;
            state     <= ST_WAIT_SAFE;
            o_intr_en <= 1'b1;
          end
        end
        ST_WAIT_SAFE: begin
          // A withdrawn request or disabled interrupts abandon entry before anything is committed.
          if (!i_irq[cause] || !i_intr_en) begin
            state <= ST_IDLE;
          end else if (ex_safe) begin
            o_epc     <= i_ex_pc;
            flush_cnt <= '0;
            state     <= ST_FLUSH;
            o_flush   <= 1'b1;
            o_intr_en <= 1'b1;
          end else begin
            o_intr_en <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state         <= ST_REDIRECT;
            o_pc_redirect <= 1'b1;
            o_pc_target   <= VECTOR_BASE + vec_offset(cause);
            o_irq_ack     <= cause_onehot(cause);
            o_intr_en     <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 3'd1;
            o_flush   <= 1'b1;
            o_intr_en <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          state    <= ST_IN_ISR;
          o_in_isr <= 1'b1;
        end
        ST_IN_ISR: begin
          if (i_ex_valid && i_ex_mret) begin
            state         <= ST_RETURN;
            o_flush       <= 1'b1;
            o_pc_redirect <= 1'b1;
            o_pc_target   <= o_epc;
          end else begin
            o_in_isr <= 1'b1;
          end
        end
        ST_RETURN: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_sequencer.sv
// Directed + randomized bench for intr_sequencer with a transaction-level reference.
module tb_intr_sequencer;

  localparam logic [31:0] VB = 32'h0000_0100;
  localparam int          FC = 2;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_irq;
  logic        i_intr_en;
  logic        i_hazard_full;
  logic        i_ex_valid;
  logic        i_ex_is_ctrl;
  logic        i_ex_mret;
  logic [31:0] i_ex_pc;
  logic        o_intr_en;
  logic        o_flush;
  logic        o_pc_redirect;
  logic [31:0] o_pc_target;
  logic [31:0] o_epc;
  logic [3:0]  o_irq_ack;
  logic        o_in_isr;

  int tests = 0;
  int fails = 0;

  intr_sequencer #(.VECTOR_BASE(VB), .FLUSH_CYCLES(FC)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_irq         (i_irq),
    .i_intr_en     (i_intr_en),
    .i_hazard_full (i_hazard_full),
    .i_ex_valid    (i_ex_valid),
    .i_ex_is_ctrl  (i_ex_is_ctrl),
    .i_ex_mret     (i_ex_mret),
    .i_ex_pc       (i_ex_pc),
    .o_intr_en     (o_intr_en),
    .o_flush       (o_flush),
    .o_pc_redirect (o_pc_redirect),
    .o_pc_target   (o_pc_target),
    .o_epc         (o_epc),
    .o_irq_ack     (o_irq_ack),
    .o_in_isr      (o_in_isr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Request an interrupt, keep EX unsafe for n_unsafe cycles, then offer a safe slot at pc.
  task automatic run_entry(input logic [3:0] irq, input int n_unsafe, input logic [31:0] pc);
    int flushes = 0;
    int redirs  = 0;
    int stray   = 0;
    bit done    = 0;
    logic [31:0] tgt = 'x;
    logic [3:0]  ack = 'x;
    i_irq = irq; i_intr_en = 1'b1; i_ex_mret = 1'b0;
    for (int k = 0; k < n_unsafe; k++) begin
      case ($urandom_range(2))
        0:       {i_ex_valid, i_ex_is_ctrl, i_hazard_full} = 3'b110;
        1:       {i_ex_valid, i_ex_is_ctrl, i_hazard_full} = 3'b101;
        default: {i_ex_valid, i_ex_is_ctrl, i_hazard_full} = 3'b010;
      endcase
      i_ex_pc = pc ^ 32'h0000_1000;
      tick();
      chk("unsafe_no_flush", {31'd0, o_flush}, 32'd0);
    end
    {i_ex_valid, i_ex_is_ctrl, i_hazard_full} = 3'b100;
    i_ex_pc = pc;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (o_flush) begin
        flushes++;
        chk("flush_intr_en", {31'd0, o_intr_en}, 32'd1);
      end
      if (o_pc_redirect) begin
        redirs++;
        tgt = o_pc_target;
        ack = o_irq_ack;
      end else if (o_irq_ack != 4'd0) begin
        stray++;
      end
      if (o_in_isr) done = 1;
    end
    chk("reached_isr",   {31'd0, done}, 32'd1);
    chk("flush_cycles",  flushes, FC);
    chk("redirect_cnt",  redirs, 1);
    chk("vector_target", tgt, VB + 32'(4 * lowest(irq)));
    chk("irq_ack",       {28'd0, ack}, 32'(1 << lowest(irq)));
    chk("stray_ack",     stray, 0);
    chk("epc_capture",   o_epc, pc);
    i_ex_pc = $urandom;
    tick();
    chk("epc_hold", o_epc, pc);
    chk("in_isr",   {31'd0, o_in_isr}, 32'd1);
  endtask

  // Stay in the handler with pend asserted, then MRET; pend must tail-chain.
  task automatic run_return(input logic [3:0] pend, input logic [31:0] epc_exp);
    i_irq = pend; i_ex_valid = 1'b1; i_ex_is_ctrl = 1'b0; i_ex_mret = 1'b0;
    repeat (2) begin
      tick();
      chk("isr_no_nest_ack", {28'd0, o_irq_ack}, 32'd0);
      chk("isr_hold",        {31'd0, o_in_isr}, 32'd1);
    end
    i_ex_mret = 1'b1;
    tick();
    i_ex_mret = 1'b0; i_ex_valid = 1'b0;
    chk("ret_flush",    {31'd0, o_flush}, 32'd1);
    chk("ret_redirect", {31'd0, o_pc_redirect}, 32'd1);
    chk("ret_target",   o_pc_target, epc_exp);
    chk("ret_not_isr",  {31'd0, o_in_isr}, 32'd0);
    tick();
    chk("idle_after_ret",   {28'd0, o_flush, o_pc_redirect, o_intr_en, o_in_isr}, 32'd0);
    chk("idle_target_zero", o_pc_target, 32'd0);
    tick();
    chk("tail_chain", {31'd0, o_intr_en}, {31'd0, pend != 4'd0});
  endtask

  task automatic drain();
    i_irq = 4'd0; i_ex_valid = 1'b0;
    tick();
    tick();
    chk("drained_idle", {31'd0, o_intr_en}, 32'd0);
  endtask

  initial begin
    logic [3:0]  irq;
    logic [3:0]  pend;
    logic [31:0] pc;
    int          n;
    int          bad;
    bit          seen;

    i_reset = 1'b1; i_irq = '0; i_intr_en = 1'b0; i_hazard_full = 1'b0;
    i_ex_valid = 1'b0; i_ex_is_ctrl = 1'b0; i_ex_mret = 1'b0; i_ex_pc = '0;
    tick();
    tick();
    chk("rst_ctrl",   {27'd0, o_intr_en, o_flush, o_pc_redirect, o_in_isr, 1'b0}, 32'd0);
    chk("rst_target", o_pc_target, 32'd0);
    chk("rst_epc",    o_epc, 32'd0);
    chk("rst_ack",    {28'd0, o_irq_ack}, 32'd0);
    i_reset = 1'b0;
    tick();

    // Interrupts disabled: request must be ignored.
    i_irq = 4'b0011; i_intr_en = 1'b0; i_ex_valid = 1'b1;
    repeat (3) tick();
    chk("disabled_ignored", {31'd0, o_intr_en}, 32'd0);

    run_entry(4'b0110, 0, 32'h40);
    run_return(4'b0000, 32'h40);
    drain();

    run_entry(4'b0001, 3, 32'h88);
    run_return(4'b0100, 32'h88);
    run_entry(4'b0100, 0, 32'h200);
    run_return(4'b0000, 32'h200);
    drain();

    // Request withdrawn while waiting for a safe slot.
    i_intr_en = 1'b1; i_irq = 4'b1000;
    {i_ex_valid, i_ex_is_ctrl, i_hazard_full} = 3'b110;
    i_ex_pc = 32'h300;
    tick();
    tick();
    chk("drop_wait_intr_en", {31'd0, o_intr_en}, 32'd1);
    i_irq = 4'b0000; i_ex_is_ctrl = 1'b0;
    bad = 0;
    repeat (5) begin
      tick();
      if (o_flush || o_pc_redirect || o_irq_ack != 4'd0) bad++;
    end
    chk("drop_no_activity", bad, 0);
    chk("drop_idle",        {31'd0, o_intr_en}, 32'd0);
    chk("drop_epc_kept",    o_epc, 32'h200);

    for (int it = 0; it < 10; it++) begin
      irq  = 4'($urandom_range(1, 15));
      pend = 4'($urandom_range(0, 15));
      n    = $urandom_range(0, 3);
      pc   = $urandom & 32'hFFFF_FFFC;
      run_entry(irq, n, pc);
      run_return(pend, pc);
      drain();
    end

    // Reset during the flush window.
    i_irq = 4'b0010; i_intr_en = 1'b1;
    {i_ex_valid, i_ex_is_ctrl, i_hazard_full} = 3'b100;
    i_ex_pc = 32'h500;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (o_flush) seen = 1;
    end
    chk("rst_mid_reached_flush", {31'd0, seen}, 32'd1);
    #2 i_reset = 1'b1;
    #1;
    chk("rst_mid_ctrl",   {28'd0, o_intr_en, o_flush, o_pc_redirect, o_in_isr}, 32'd0);
    chk("rst_mid_ack",    {28'd0, o_irq_ack}, 32'd0);
    chk("rst_mid_epc",    o_epc, 32'd0);
    chk("rst_mid_target", o_pc_target, 32'd0);
    i_irq = 4'd0;
    tick();
    i_reset = 1'b0;
    bad = 0;
    repeat (6) begin
      tick();
      if (o_pc_redirect || o_irq_ack != 4'd0 || o_flush) bad++;
    end
    chk("rst_no_redirect", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
